four_bit_seq_divider: RTL and testbench
=======================================

FOUR_BIT_SEQ_DIVIDER -- requirements
Module: four_bit_seq_divider

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-004 SHALL have port: dividend  input  4  unsigned dividend; captured on accepted start.
REQ-005 SHALL have port: divisor  input  4  unsigned divisor; captured on accepted start.
REQ-006 SHALL have port: quotient  output  4  unsigned quotient, registered.
REQ-007 SHALL have port: remainder  output  4  unsigned remainder, registered.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: dz  output  1  divide-by-zero flag, registered.
REQ-011 SHALL have parameter: WIDTH, default 4, meaning operand width; only 4 is required to be supported.

Function
REQ-012 SHALL implement three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 with divisor!=0 SHALL capture both operands, clear partial remainder (5 bits) and cycle count, clear dz, and go to RUN next cycle.
REQ-014 IDLE: start=1 with divisor==0 SHALL go directly to DONE next cycle with dz=1, quotient=4'hF, remainder=dividend.
REQ-015 RUN: each cycle SHALL perform one restoring step, MSB first: R' = {R[3:0], next dividend bit}; D = R' - {0,divisor}; if no borrow then R=D and quotient bit=1, else R=R' and quotient bit=0.
REQ-016 RUN SHALL last exactly 4 cycles; after the 4th step the state SHALL be DONE.
REQ-017 DONE SHALL last exactly 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-018 Latency: for nonzero divisor, done SHALL assert on the 5th rising edge after the edge that accepted start; for divisor 0, on the 1st.
REQ-019 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-020 start SHALL be ignored in RUN and DONE, with no queuing, including start coincident with the DONE cycle.
REQ-021 quotient, remainder and dz SHALL hold their last values from DONE through IDLE until the next accepted start.
REQ-022 Operand changes after an accepted start SHALL NOT affect the result in progress.
REQ-023 The result SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all 240 nonzero-divisor pairs.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and set quotient=0, remainder=0, busy=0, done=0, dz=0, count=0.
REQ-025 rst SHALL take priority over start and over any state, including mid-RUN and DONE; an aborted division SHALL produce no done pulse.

Structure
REQ-026 State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the width constant SHALL reside in a shared package/header included by the divider and its bench.
REQ-027 The trial subtraction SHALL be a separate combinational sub-module, four_bit_trial_subtractor (5-bit minuend, 4-bit subtrahend, 5-bit difference, borrow out), built as a ripple of one-bit full-adder cells with inverted subtrahend and carry-in 1.
REQ-028 The FSM, shift registers and counter SHALL reside in four_bit_seq_divider; no other sub-modules.

Verification
REQ-029 13/4: start pulse -> busy for 4 cycles, done at edge 5, quotient=3, remainder=1, dz=0.
REQ-030 15/1 then 3/7 back-to-back (second start in the cycle after DONE) -> 15 r 0, then 0 r 3; each done is a single cycle.
REQ-031 9/0 -> done at edge 1, dz=1, quotient=15, remainder=9, busy never high.
REQ-032 Start 12/5; during RUN drive start=1 with 1/1 and change the operands -> result 2 r 2, one done pulse only.
REQ-033 rst asserted in the 2nd RUN cycle of 14/3 -> next edge IDLE, all outputs 0, no done; a subsequent 14/3 -> 4 r 2.
REQ-034 Exhaustive sweep of all 256 operand pairs checked against a reference model (REQ-014, REQ-023).

Source files
------------

// File: rtl/four_bit_seq_divider_pkg.sv
// Shared constants and state encoding for the
// sequential restoring divider and its bench.
package four_bit_seq_divider_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_trial_subtractor.sv
// Trial subtraction for one restoring step:
// ripple of full-adder cells computing a + ~b + 1.
module four_bit_trial_subtractor
  import four_bit_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH:0]   difference,
  output logic             borrow
);

  logic [WIDTH:0] nb;
  logic           c;

  assign nb = ~{1'b0, subtrahend};

  // carry-out of the top cell low means a borrow
  always_comb begin
    difference = '0;
    c = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      difference[i] = minuend[i] ^ nb[i] ^ c;
      c = (minuend[i] & nb[i]) |
          (c & (minuend[i] ^ nb[i]));
    end
    borrow = ~c;
  end

endmodule

// File: rtl/four_bit_seq_divider.sv
// Sequential restoring divider: one quotient bit
// per RUN cycle, MSB first, registered results.
module four_bit_seq_divider
  import four_bit_seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             qbit;

  // dividend bits leave at the top while
  // quotient bits enter at the bottom
  assign trial = (WIDTH+1)'({rem, dvd[WIDTH-1]});

  four_bit_trial_subtractor #(
    .WIDTH(WIDTH)
  ) u_sub (
    .minuend   (trial),
    .subtrahend(dvs),
    .difference(diff),
    .borrow    (borrow)
  );

  assign qbit     = ~borrow;
  assign next_rem = borrow ? trial : diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      count     <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              dz        <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dvd   <= dividend;
              dvs   <= divisor;
              rem   <= '0;
              count <= '0;
              dz    <= 1'b0;
            end
          end
        end
        RUN: begin
          rem   <= next_rem;
          dvd   <= {dvd[WIDTH-2:0], qbit};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {dvd[WIDTH-2:0], qbit};
            remainder <= next_rem[WIDTH-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Bench for four_bit_seq_divider: timeline model
// checked every cycle plus directed literal cases.
module tb_four_bit_seq_divider;
  import four_bit_seq_divider_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DIV_W-1:0] dividend = '0;
  logic [DIV_W-1:0] divisor = '0;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dz;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  four_bit_seq_divider #(.WIDTH(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // timeline model: a job occupies 4 busy cycles then one done cycle
  int       run_left = 0;
  bit       m_done = 1'b0;
  bit       m_dz = 1'b0;
  int       m_q = 0;
  int       m_r = 0;
  int       pq = 0;
  int       pr = 0;

  always @(posedge clk) begin
    if (rst) begin
      run_left = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) begin
        m_done = 1; m_q = pq; m_r = pr;
      end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1; m_dz = 1; m_q = 15; m_r = int'(dividend);
      end else begin
        run_left = 4; m_dz = 0;
        pq = int'(dividend) / int'(divisor);
        pr = int'(dividend) % int'(divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", int'(busy), int'(run_left > 0));
      chk("model_done", int'(done), int'(m_done));
      chk("model_dz", int'(dz), int'(m_dz));
      chk("model_quotient", int'(quotient), m_q);
      chk("model_remainder", int'(remainder), m_r);
    end
  end

  // called at a negedge in IDLE; returns at the negedge after DONE
  task automatic do_div(input int a, input int b, input int elat,
                        input int eq, input int er, input int edz,
                        input string nm);
    int lat;
    int busy_n;
    busy_n = 0;
    start = 1'b1;
    dividend = DIV_W'(a);
    divisor = DIV_W'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, busy_n, elat - 1);
    chk({nm, "_q"}, int'(quotient), eq);
    chk({nm, "_r"}, int'(remainder), er);
    chk({nm, "_dz"}, int'(dz), edz);
    @(negedge clk);
    chk({nm, "_done_single"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    int dn;
    int q;
    int r;
    repeat (2) @(negedge clk);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(dz), 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    chk_en = 1'b1;

    do_div(13, 4, 5, 3, 1, 0, "d13_4");
    do_div(15, 1, 5, 15, 0, 0, "d15_1");
    do_div(3, 7, 5, 0, 3, 0, "d3_7");
    do_div(9, 0, 1, 15, 9, 1, "d9_0");

    // operand changes and start held high during RUN and DONE
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    dividend = 4'd1; divisor = 4'd1;
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("intf_latency", lat, 5);
    chk("intf_q", int'(quotient), 2);
    chk("intf_r", int'(remainder), 2);
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    repeat (6) begin
      dn += int'(done);
      @(negedge clk);
    end
    chk("intf_no_extra_done", dn, 0);

    // reset in the second RUN cycle
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", int'(dut.state), int'(IDLE));
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    dn = 0;
    repeat (6) begin
      dn += int'(done);
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    do_div(14, 3, 5, 4, 2, 0, "d14_3");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        q = (b == 0) ? 15 : a / b;
        r = (b == 0) ? a : a % b;
        do_div(a, b, (b == 0) ? 1 : 5, q, r, int'(b == 0), "sweep");
        if (b != 0) begin
          chk("sweep_identity",
              int'(quotient) * b + int'(remainder), a);
          chk("sweep_rem_lt", int'(int'(remainder) < b), 1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
